// File: rtl/isa_io_sequencer.sv
// isa_io_sequencer: ISA I/O slave cycle sequencer with address decode and SD drive control.
module isa_io_sequencer #(
  parameter logic [15:0] JOY_BASE = 16'h0201,
  parameter logic [15:0] SB_BASE = 16'h0220,
  parameter logic [15:0] FM_BASE = 16'h0388,
  parameter logic [15:0] MPU_BASE = 16'h0330,
  parameter int SYNC_STAGES = 2,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bale,
  input  logic [15:0] sa,
  input  logic        aen,
  input  logic        ior_n,
  input  logic        iow_n,
  input  logic        sbhe_n,
  input  logic [15:0] sd_in,
  input  logic [7:0]  dev_rdata,
  output logic [3:0]  dev_sel,
  output logic [3:0]  dev_addr,
  output logic        rd_stb,
  output logic        wr_stb,
  output logic [7:0]  wr_data,
  output logic [15:0] sd_out,
  output logic        sd_oe,
  output logic        bus_err
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_HOLD, WR_HOLD, RECOVER} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_bale_s, r_ior_s, r_iow_s;
  logic        r_sbhe_q, r_aen, r_lat_pend, r_rd_stb, r_wr_stb, r_sd_oe, r_bus_err;
  logic [15:0] r_sd_q, r_sa, r_sd_out;
  logic [3:0]  r_dev_sel, r_dev_addr, r_cnt;
  logic [7:0]  r_wr_data;
  logic        w_bale_fall, w_ior_fall, w_iow_fall, w_iow_rise, w_ior_hi, w_ior_lo, w_iow_lo;
  logic        w_rd, w_wr, w_err, w_oe, w_cap;
  logic [3:0]  w_dec;
  // Edges come from the last two sync stages; levels from the final stage.
  assign w_bale_fall = r_bale_s[SYNC_STAGES-1] & ~r_bale_s[SYNC_STAGES-2];
  assign w_ior_fall  = r_ior_s[SYNC_STAGES-1] & ~r_ior_s[SYNC_STAGES-2];
  assign w_iow_fall  = r_iow_s[SYNC_STAGES-1] & ~r_iow_s[SYNC_STAGES-2];
  assign w_iow_rise  = ~r_iow_s[SYNC_STAGES-1] & r_iow_s[SYNC_STAGES-2];
  assign w_ior_hi    = r_ior_s[SYNC_STAGES-1];
  assign w_ior_lo    = ~r_ior_s[SYNC_STAGES-1];
  assign w_iow_lo    = ~r_iow_s[SYNC_STAGES-1];
  assign w_dec = r_aen ? 4'b0000 : {
    (r_sa >= MPU_BASE) && (r_sa <= MPU_BASE + 16'd1),
    (r_sa >= FM_BASE) && (r_sa <= FM_BASE + 16'd3),
    (r_sa >= SB_BASE) && (r_sa <= SB_BASE + 16'd15),
    r_sa == JOY_BASE};
  always_comb begin
    w_next = r_state;
    w_rd = 1'b0;
    w_wr = 1'b0;
    w_err = 1'b0;
    w_oe = r_sd_oe;
    w_cap = 1'b0;
    case (r_state)
      IDLE: begin
        if ((w_ior_fall & (w_iow_fall | w_iow_lo)) | (w_iow_fall & w_ior_lo)) w_err = 1'b1;
        else if (w_ior_fall && |r_dev_sel) begin
          w_rd = 1'b1;
          w_oe = 1'b1;
          w_next = RD_WAIT;
        end else if (w_iow_fall && |r_dev_sel) w_next = WR_HOLD;
      end
      RD_WAIT: begin
        w_err = w_iow_fall;
        if (w_ior_hi) begin
          w_oe = 1'b0;
          w_next = RECOVER;
        end else if (r_cnt == 4'd1) begin
          w_cap = 1'b1;
          w_next = RD_HOLD;
        end
      end
      RD_HOLD: begin
        w_err = w_iow_fall;
        if (w_ior_hi) begin
          w_oe = 1'b0;
          w_next = RECOVER;
        end
      end
      WR_HOLD: begin
        w_err = w_ior_fall;
        if (w_iow_rise) begin
          w_wr = 1'b1;
          w_next = RECOVER;
        end
      end
      RECOVER: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bale_s <= '0;
      r_ior_s <= '1;
      r_iow_s <= '1;
      r_sbhe_q <= 1'b1;
      r_sd_q <= '0;
      r_sa <= '0;
      r_aen <= 1'b0;
      r_lat_pend <= 1'b0;
      r_dev_sel <= '0;
      r_dev_addr <= '0;
      r_cnt <= '0;
      r_rd_stb <= 1'b0;
      r_wr_stb <= 1'b0;
      r_wr_data <= '0;
      r_sd_out <= '0;
      r_sd_oe <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_bale_s <= {r_bale_s[SYNC_STAGES-2:0], bale};
      r_ior_s <= {r_ior_s[SYNC_STAGES-2:0], ior_n};
      r_iow_s <= {r_iow_s[SYNC_STAGES-2:0], iow_n};
      r_sbhe_q <= sbhe_n;
      r_sd_q <= sd_in;
      r_lat_pend <= w_bale_fall && r_state == IDLE;
      if (w_bale_fall && r_state == IDLE) begin
        r_sa <= sa;
        r_aen <= aen;
      end
      if (r_lat_pend) begin
        r_dev_sel <= w_dec;
        r_dev_addr <= r_sa[3:0];
      end
      r_cnt <= w_rd ? 4'(RD_LAT) : (r_state == RD_WAIT ? r_cnt - 4'd1 : r_cnt);
      r_rd_stb <= w_rd;
      r_wr_stb <= w_wr;
      r_bus_err <= w_err;
      r_sd_oe <= w_oe;
      if (w_wr) r_wr_data <= (!r_sbhe_q && r_dev_addr[0]) ? r_sd_q[15:8] : r_sd_q[7:0];
      if (w_cap) r_sd_out <= {dev_rdata, dev_rdata};
    end
  end
  assign dev_sel = r_dev_sel;
  assign dev_addr = r_dev_addr;
  assign rd_stb = r_rd_stb;
  assign wr_stb = r_wr_stb;
  assign wr_data = r_wr_data;
  assign sd_out = r_sd_out;
  assign sd_oe = r_sd_oe;
  assign bus_err = r_bus_err;
endmodule

// File: doc/isa_io_sequencer.md
Name: isa_io_sequencer

Overview:
- Sequences ISA I/O slave cycles for the sound card: syncs ISA strobes into the clk domain, latches and decodes the address on BALE, and issues one-cycle read/write strobes to the joystick, SB, FM or MPU sub-block.
- Owns the SD output drive and its turnaround (SD70_DIR/SD158_DIR = !sd_oe).
- Sits between the ISA pins and the sound/mpu instances, replacing the ad-hoc edge detection and chip-select logic at top level.

Parameters:
- JOY_BASE, 16'h0201, joystick port (1 address)
- SB_BASE, 16'h0220, Sound Blaster base (16 addresses)
- FM_BASE, 16'h0388, OPL base (4 addresses)
- MPU_BASE, 16'h0330, MPU-401 base (2 addresses)
- SYNC_STAGES, 2, synchroniser depth for bale/ior_n/iow_n, min 2
- RD_LAT, 2, clk cycles from rd_stb to dev_rdata capture, 1..15

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bale  in  1  ISA BALE, async
- sa  in  16  ISA SA[15:0]
- aen  in  1  ISA AEN, high = DMA cycle
- ior_n  in  1  ISA IOR#, async
- iow_n  in  1  ISA IOW#, async
- sbhe_n  in  1  ISA SBHE#
- sd_in  in  16  ISA SD as input
- dev_rdata  in  8  read data from the device selected by dev_sel
- dev_sel  out  4  one-hot {mpu, fm, sb, joy}, 0 = not ours
- dev_addr  out  4  latched sa[3:0]
- rd_stb  out  1  one-cycle read strobe
- wr_stb  out  1  one-cycle write strobe
- wr_data  out  8  write byte, valid with wr_stb
- sd_out  out  16  ISA read data {byte, byte}
- sd_oe  out  1  drive SD and pull DIR pins low
- bus_err  out  1  one-cycle pulse on an illegal strobe combination

Behaviour:
- Sync: bale, ior_n and iow_n each pass through SYNC_STAGES flops; reset values 0, 1, 1. Edge detection uses the last two stages. sbhe_n and sd_in are single-registered (sbhe_q, sd_q).
- Address latch: on synced bale falling edge while state==IDLE, register sa and aen. Decode on the following edge:
  - joy: sa==JOY_BASE
  - sb: SB_BASE..SB_BASE+15
  - fm: FM_BASE..FM_BASE+3
  - mpu: MPU_BASE..MPU_BASE+1
  - aen=1 forces dev_sel=0.
  - dev_sel and dev_addr hold until the next latch.
  - A BALE edge outside IDLE is ignored.
- FSM states: IDLE, RD_WAIT, RD_HOLD, WR_HOLD, RECOVER.
- IDLE:
  - synced ior_n fall with dev_sel!=0 → rd_stb=1 for exactly the next cycle, sd_oe=1 from that same cycle, load counter RD_LAT, go RD_WAIT.
  - synced iow_n fall with dev_sel!=0 → WR_HOLD.
  - dev_sel==0 → no strobe, sd_oe stays 0.
- RD_WAIT: decrement counter each cycle. At 0, sd_out<={dev_rdata,dev_rdata} → RD_HOLD.
- RD_HOLD: sd_out frozen. Synced ior_n high → sd_oe=0 → RECOVER. If ior_n rises during RD_WAIT, still deassert sd_oe and go RECOVER without capture.
- WR_HOLD: on synced iow_n rise, wr_stb=1 for one cycle → RECOVER.
  - wr_data = sd_q[15:8] if sbhe_q==0 and dev_addr[0]==1, else sd_q[7:0], sampled on the cycle the rise is detected.
- RECOVER: one cycle, all strobes 0 → IDLE.
- Both synced strobes low in IDLE: bus_err=1 for one cycle, no strobe, stay IDLE. In any other state, the opposite strobe falling also pulses bus_err and is otherwise ignored.
- At most one rd_stb or wr_stb per ISA cycle. rd_stb and wr_stb are never high together.
- Reset (sync): all outputs 0 next clk edge, FSM→IDLE, sync flops to their reset values. A reset mid-read drops sd_oe on that edge.
- Latency from pin edge to strobe: SYNC_STAGES+1 cycles. The read path must satisfy ISA timing at 8 MHz clk with defaults: strobe at +3, capture at +5 cycles.

Test Plan:
- BALE with sa=0x0388, aen=0, then IOR# low 10 cycles, dev_rdata=0x5A → dev_sel=4'b0100, dev_addr=8, one rd_stb, sd_out=0x5A5A, sd_oe high until 1 cycle after synced IOR# rise, then RECOVER→IDLE.
- sa=0x0331, sbhe_n=0, sd_in=0xC300, IOW# pulse → dev_sel=4'b1000, single wr_stb with wr_data=0xC3. Repeat with sa=0x0330 → wr_data=0x00.
- sa=0x022C with aen=1, IOR# pulse → dev_sel=0, no rd_stb, sd_oe never asserted. Same with sa=0x0240, aen=0.
- IOR# and IOW# low simultaneously in IDLE → bus_err single pulse, no strobes, FSM stays IDLE.
- Read in progress (sd_oe=1), assert reset one cycle → sd_oe=0, dev_sel=0 next edge; a following clean read to 0x0201 works.
- Second BALE with sa=0x0220 during RD_HOLD → dev_sel unchanged. After RECOVER, next BALE latches 0x0220 → dev_sel=4'b0010.
